// File: rtl/slot_arbiter_pkg.sv
// Shared types and constants for the slot arbiter.
package slot_arbiter_pkg;

  localparam int SLOT_W   = 3;
  localparam int MAX_SLOT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/slot_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface slot_arbiter_if
  import slot_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   rel;
  logic [SLOT_W-1:0] slot_len;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_id;
  logic              busy;
  logic [SLOT_W-1:0] slot_cnt;
  logic              expire;

  modport master (
    output req, rel, slot_len,
    input  gnt, gnt_id, busy, slot_cnt, expire
  );

  modport slave (
    input  req, rel, slot_len,
    output gnt, gnt_id, busy, slot_cnt, expire
  );

endinterface

// File: rtl/slot_arbiter_slot_timer.sv
// Slot counter: enabled up-counter with synchronous clear and end-of-slot flag.
module slot_timer
  import slot_arbiter_pkg::*;
#(
  parameter int W = SLOT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] len,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] r_cnt;

  // Count cycles of the current slot; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt  = r_cnt;
  assign last = (r_cnt == len);

endmodule

// File: rtl/slot_arbiter.sv
// Round-robin arbiter granting time slots of programmable length.
module slot_arbiter
  import slot_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic         clk,
  input logic         rst,
  slot_arbiter_if.slave bus
);

  localparam int unsigned NR = NREQ;

  state_t            r_state;
  state_t            w_next;
  logic [NREQ-1:0]   r_gnt;
  logic [IDW-1:0]    r_gnt_id;
  logic [IDW-1:0]    r_ptr;
  logic [SLOT_W-1:0] r_len;
  logic [IDW-1:0]    w_win;
  logic              w_found;
  logic [SLOT_W-1:0] w_cnt;
  logic              w_last;
  logic              w_own_req;
  logic              w_own_rel;
  logic              w_end;
  logic              w_arb;

  assign w_own_req = bus.req[r_gnt_id];
  assign w_own_rel = bus.rel[r_gnt_id];
  assign w_arb     = (r_state != GRANT);
  assign w_end     = (r_state == GRANT) && (w_last || w_own_rel || !w_own_req);

  // Winner search: first set request scanning upward from ptr+1, wrapping at NREQ.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned i = 1; i <= NR; i++) begin
      idx = 32'(r_ptr) + i;
      if (idx >= NR) begin
        idx = idx - NR;
      end
      if (!w_found && bus.req[IDW'(idx)]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
  end

  // Next-state logic: arbitrate in IDLE/GAP, leave GRANT on count, release or drop.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, GAP: w_next = w_found ? GRANT : IDLE;
      GRANT:     if (w_end) w_next = GAP;
      default:   w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant, owner, round-robin pointer and latched slot length.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_len    <= '0;
      r_ptr    <= IDW'(NREQ - 1);
    end else if (w_arb && w_found) begin
      r_gnt    <= NREQ'(1) << w_win;
      r_gnt_id <= w_win;
      r_len    <= bus.slot_len;
      r_ptr    <= w_win;
    end else if (w_end) begin
      r_gnt    <= '0;
      r_gnt_id <= '0;
    end
  end

  slot_timer #(.W(SLOT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_arb || w_end),
    .en   (r_state == GRANT),
    .len  (r_len),
    .cnt  (w_cnt),
    .last (w_last)
  );

  assign bus.gnt      = r_gnt;
  assign bus.gnt_id   = r_gnt_id;
  assign bus.busy     = (r_state == GRANT);
  assign bus.slot_cnt = w_cnt;
  // Expire is combinational on the last count; masking with rst keeps a slot
  // aborted by reset from ever showing the pulse.
  assign bus.expire   = !rst && (r_state == GRANT) && w_last && !w_own_rel && w_own_req;

endmodule

// File: tb/tb_slot_arbiter.sv
// Scoreboard bench for slot_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural slot model.
module tb_slot_arbiter;
  import slot_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int BOUND = NREQ * (MAX_SLOT + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  slot_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  slot_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic [2:0] cnt;
    logic       exp;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: owner (-1 = nobody), cycles elapsed, slot length, last winner.
  int m_own = -1;
  int m_cnt = 0;
  int m_len = 0;
  int m_ptr = NREQ - 1;

  // Apply one cycle of inputs, predict this cycle's outputs, advance the model.
  task automatic drive(input logic [3:0] rq, input logic [3:0] rl,
                       input logic [2:0] sl, input logic r);
    obs_t e;
    int   w;
    @(posedge clk);
    #1;
    bus.req      = rq;
    bus.rel      = rl;
    bus.slot_len = sl;
    rst          = r;
    e.gnt  = (m_own >= 0) ? 4'(1 << m_own) : 4'd0;
    e.id   = (m_own >= 0) ? 2'(m_own) : 2'd0;
    e.busy = (m_own >= 0);
    e.cnt  = (m_own >= 0) ? 3'(m_cnt) : 3'd0;
    e.exp  = !r && (m_own >= 0) && (m_cnt == m_len) && !rl[m_own] && rq[m_own];
    exp_q.push_back(e);
    if (r) begin
      m_own = -1; m_cnt = 0; m_len = 0; m_ptr = NREQ - 1;
    end else if (m_own >= 0) begin
      if (m_cnt == m_len || rl[m_own] || !rq[m_own]) begin
        m_own = -1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (w < 0 && rq[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      if (w >= 0) begin
        m_own = w; m_ptr = w; m_len = int'(sl); m_cnt = 0;
      end
    end
  endtask

  // Monitor: pop one prediction per cycle and compare on the falling edge.
  obs_t mon_a;
  obs_t mon_e;
  int   wait_c[NREQ];
  initial for (int i = 0; i < NREQ; i++) wait_c[i] = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {bus.gnt, bus.gnt_id, bus.busy, bus.slot_cnt, bus.expire};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL cycle t=%0t: got gnt=%b id=%0d busy=%b cnt=%0d expire=%b, want gnt=%b id=%0d busy=%b cnt=%0d expire=%b",
                 $time, mon_a.gnt, mon_a.id, mon_a.busy, mon_a.cnt, mon_a.exp,
                 mon_e.gnt, mon_e.id, mon_e.busy, mon_e.cnt, mon_e.exp);
      end
      checks++;
      if (!$onehot0(bus.gnt)) begin
        errors++;
        $display("FAIL onehot: gnt=%b, want at most one bit set", bus.gnt);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.gnt[i]) begin
          if (wait_c[i] > 0) begin
            checks++;
            if (wait_c[i] > BOUND) begin
              errors++;
              $display("FAIL starvation req%0d: waited %0d cycles, limit %0d", i, wait_c[i], BOUND);
            end
          end
          wait_c[i] = 0;
        end else if (bus.req[i] && !rst) begin
          wait_c[i]++;
        end else begin
          wait_c[i] = 0;
        end
      end
    end
  end

  logic [3:0] rl;
  logic [3:0] rq;
  logic [2:0] sl;

  initial begin
    bus.req = '0; bus.rel = '0; bus.slot_len = '0;
    // Single requester, slot_len=3: three 4-cycle slots with one-cycle gaps.
    repeat (2) drive(4'b0000, 4'b0000, 3'd0, 1'b1);
    repeat (16) drive(4'b0010, 4'b0000, 3'd3, 1'b0);
    // Round robin with 1-cycle slots.
    drive(4'b0000, 4'b0000, 3'd0, 1'b1);
    repeat (10) drive(4'b1111, 4'b0000, 3'd0, 1'b0);
    // Early release by owner 1; rel[3] from a non-owner is ignored.
    drive(4'b0000, 4'b0000, 3'd0, 1'b1);
    repeat (12) begin
      rl = (m_own == 1 && m_cnt == 1) ? 4'b1000 :
           (m_own == 1 && m_cnt == 2) ? 4'b0010 : 4'b0000;
      drive(4'b0010, rl, 3'd7, 1'b0);
    end
    // Release coincident with the final count.
    drive(4'b0000, 4'b0000, 3'd0, 1'b1);
    repeat (8) begin
      rl = (m_own >= 0 && m_cnt == 2) ? 4'(1 << m_own) : 4'b0000;
      drive(4'b0100, rl, 3'd2, 1'b0);
    end
    // Owner drops its request mid-slot.
    drive(4'b0000, 4'b0000, 3'd0, 1'b1);
    repeat (10) begin
      rq = (m_own == 3 && m_cnt == 3) ? 4'b0000 : 4'b1000;
      drive(rq, 4'b0000, 3'd5, 1'b0);
    end
    // slot_len changed 7 -> 1 during a slot: 8-cycle slot, then 2-cycle slot.
    drive(4'b0000, 4'b0000, 3'd0, 1'b1);
    drive(4'b0001, 4'b0000, 3'd7, 1'b0);
    repeat (12) drive(4'b0001, 4'b0000, 3'd1, 1'b0);
    // Reset on the third cycle of a grant to requester 2, then req=0101.
    drive(4'b0000, 4'b0000, 3'd0, 1'b1);
    drive(4'b0100, 4'b0000, 3'd7, 1'b0);
    repeat (2) drive(4'b0100, 4'b0000, 3'd7, 1'b0);
    drive(4'b0101, 4'b0000, 3'd7, 1'b1);
    repeat (4) drive(4'b0101, 4'b0000, 3'd7, 1'b0);
    // Random traffic with sticky requests, sparse releases and rare resets.
    rq = 4'b0000;
    repeat (2000) begin
      if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
      rl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      sl = 3'($urandom_range(0, 7));
      drive(rq, rl, sl, ($urandom_range(0, 199) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slot_arbiter.md
SLOT_ARBITER -- requirements
Module: slot_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; legal values 2..8.
REQ-002 Parameter IDW, default 2, width of gnt_id; SHALL equal ceil(log2(NREQ)).
REQ-003 clk  input  1  rising-edge clock; the block's only clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  NREQ  level request, one bit per requester.
REQ-006 rel  input  NREQ  early-release strobe; only the current owner's bit has effect.
REQ-007 slot_len  input  3  slot length minus one (0 gives 1 cycle, 7 gives 8 cycles); sampled at arbitration.
REQ-008 gnt  output  NREQ  one-hot grant, or all zero.
REQ-009 gnt_id  output  IDW  index of the current owner; 0 when gnt is all zero.
REQ-010 busy  output  1  high while in state GRANT.
REQ-011 slot_cnt  output  3  cycles elapsed in the current slot, starting at 0.
REQ-012 expire  output  1  one-cycle pulse on the last cycle of a slot that ends by count.

Function
REQ-013 The FSM SHALL have three states: IDLE, GRANT and GAP.
REQ-014 Arbitration SHALL occur in IDLE and GAP only.
  - Winner: first set req bit searching upward from ptr+1, modulo NREQ.
  - If a winner exists: next state GRANT; gnt and gnt_id are registered to it; slot_len is latched into len_q; slot_cnt is cleared to 0; ptr becomes the winner.
  - If no winner exists: next state IDLE.
REQ-015 Grant latency SHALL be 1 cycle: gnt goes high on the edge after req is seen in IDLE or GAP.
REQ-016 In GRANT, slot_cnt SHALL increment by 1 per cycle, using 3-bit wrap-free arithmetic (it never exceeds len_q).
REQ-017 GRANT SHALL end (next state GAP, gnt cleared) on the first cycle that meets any of these:
  - slot_cnt == len_q
  - rel[owner] == 1
  - req[owner] == 0
REQ-018 With no early end, gnt SHALL be held for exactly len_q+1 cycles.
REQ-019 expire SHALL be high only when slot_cnt == len_q and neither rel[owner] nor !req[owner] is active in that cycle.
REQ-020 GAP SHALL last exactly 1 cycle, with gnt all zero, busy 0 and slot_cnt 0.
REQ-021 rel bits of non-owners, and rel bits while not in GRANT, SHALL be ignored.
REQ-022 Changes to slot_len during GRANT SHALL NOT affect the current slot.
REQ-023 Requester starvation bound: any requester holding req continuously SHALL be granted within NREQ*(8+1) cycles.
REQ-024 gnt SHALL never have more than one bit set.
REQ-025 busy SHALL equal (gnt != 0).

Reset
REQ-026 When rst is sampled high, the block SHALL on that edge set state=IDLE, gnt=0, gnt_id=0, busy=0, slot_cnt=0, expire=0, len_q=0 and ptr=NREQ-1 (so requester 0 has first priority).
REQ-027 rst SHALL override all other inputs, including in the middle of a slot; no expire pulse is produced for a slot aborted by reset.
REQ-028 Arbitration SHALL resume normally on the first cycle with rst low.

Structure
REQ-029 A shared package SHALL hold:
  - the state enum type (IDLE, GRANT, GAP);
  - the constant SLOT_W = 3;
  - the constant MAX_SLOT = 8.
REQ-030 One sub-module, slot_timer, SHALL be used for the slot counter.
  - Ports: clk, rst, clr, en, len, cnt, last.
  - It is a 3-bit enabled counter with synchronous clear.
  - last = (cnt == len).
REQ-031 The round-robin winner search SHALL be combinational logic inside slot_arbiter.

Verification
REQ-032 Reset mid-slot: rst pulsed on cycle 3 of a grant to requester 2 -> gnt=0, slot_cnt=0 on the next edge, no expire; next grant goes to requester 0 when req=4'b0101.
REQ-033 Single requester: req=4'b0010 held, slot_len=3 -> gnt=4'b0010 for 4 cycles, expire on the 4th, 1 GAP cycle, then re-grant; repeat for 3 slots.
REQ-034 Round robin: req=4'b1111 held, slot_len=0 -> grant order 0,1,2,3,0 with GRANT/GAP alternating every cycle.
REQ-035 Early release: owner 1, slot_len=7, rel[1] pulsed at slot_cnt=2 -> gnt drops after 3 cycles, expire stays 0; rel[3] pulsed during the slot -> no effect.
REQ-036 Release coincident with expiry: slot_len=2, rel[owner] at slot_cnt=2 -> slot ends, expire=0.
REQ-037 Request drop and slot_len change: req[owner] deasserted mid-slot -> next state GAP; slot_len changed 7->1 during a slot -> current slot still lasts 8 cycles, next slot lasts 2.
